// File: rtl/alu_share_if.sv
// Request/response bundle between two issuing blocks, their response consumer and the
// shared-ALU arbiter. Requester i uses ctrl bits [2i+1:2i] and operand bits [N*i +: N].
interface alu_share_if #(parameter int N = 32);
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [3:0]     req_ctrl;
   logic [2*N-1:0] req_a;
   logic [2*N-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [N-1:0]   rsp_r;
   logic           rsp_o;
   logic           rsp_n;
   logic           rsp_z;

   modport master (
      output req_valid, req_ctrl, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z
   );

   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters (IDLE/EXEC/RESP).
// Optional ALU_STICKY_OVF_EN adds per-requester sticky overflow bits with clear inputs.
module alu_share_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_share_if.slave   bus,
   output logic [1:0]   alu_ctrl,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_r,
   input  logic         alu_o,
   input  logic         alu_n,
   input  logic         alu_z,
   output logic         busy
`ifdef ALU_STICKY_OVF_EN
   ,
   output logic [1:0]   ovf_sticky,
   input  logic [1:0]   ovf_clr
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state, state_nxt;
   logic         last;
   logic         win;
   logic [1:0]   grant;
   logic         hs;
   logic         rsp_id_q;
   logic [N-1:0] rsp_r_q;
   logic         rsp_o_q, rsp_n_q, rsp_z_q;

   // Winner is ~last only on a tie; a lone requester always wins.
   always_comb begin
      win   = (bus.req_valid == 2'b11) ? ~last : bus.req_valid[1];
      grant = 2'b00;
      if (rst_n && state == IDLE && |bus.req_valid)
         grant = win ? 2'b10 : 2'b01;
      hs    = |(grant & bus.req_valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last     <= 1'b1;
         alu_ctrl <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         rsp_id_q <= 1'b0;
         rsp_r_q  <= '0;
         rsp_o_q  <= 1'b0;
         rsp_n_q  <= 1'b0;
         rsp_z_q  <= 1'b0;
      end else begin
         if (hs) begin
            alu_ctrl <= bus.req_ctrl[2*win +: 2];
            alu_a    <= bus.req_a[N*win +: N];
            alu_b    <= bus.req_b[N*win +: N];
            rsp_id_q <= win;
            last     <= win;
         end
         if (state == EXEC) begin
            rsp_r_q <= alu_r;
            rsp_o_q <= alu_o;
            rsp_n_q <= alu_n;
            rsp_z_q <= alu_z;
         end
      end
   end

`ifdef ALU_STICKY_OVF_EN
   // Set is ORed in after the clear so a same-cycle set survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++)
            ovf_sticky[i] <= (ovf_sticky[i] & ~ovf_clr[i]) |
                             (state == EXEC && alu_o && rsp_id_q == i[0]);
      end
   end
`endif

   assign bus.req_ready = grant;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_r     = rsp_r_q;
   assign bus.rsp_o     = rsp_o_q;
   assign bus.rsp_n     = rsp_n_q;
   assign bus.rsp_z     = rsp_z_q;
   assign busy          = (state != IDLE);

endmodule
